// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; misaligned or illegal requests fault without a memory access.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_STORE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    function automatic logic req_is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic flt;
        if (we) begin
            case (f3)
                3'b000:  flt = 1'b0;
                3'b001:  flt = a[0];
                3'b010:  flt = (a != 2'b00);
                default: flt = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b100: flt = 1'b0;
                3'b001, 3'b101: flt = a[0];
                3'b010:         flt = (a != 2'b00);
                default:        flt = 1'b1;
            endcase
        end
        return flt;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = word >> {a, 3'b000};
        half_sh = word >> {a[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  res = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  res = {24'h000000, byte_sh[7:0]};
            3'b101:  res = {16'h0000, half_sh[15:0]};
            3'b010:  res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] ins;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {a, 3'b000};
                ins  = (wd & 32'h0000_00FF) << {a, 3'b000};
            end
            3'b001: begin
                mask = 32'h0000_FFFF << {a[1], 4'b0000};
                ins  = (wd & 32'h0000_FFFF) << {a[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wd;
            end
        endcase
        return (word & ~mask) | ins;
    endfunction

    // Next-state and request-latch logic
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0000_0000;
                    fault_d  = req_is_fault(req_we, req_funct3, req_addr[1:0]);
                    if (fault_d) begin
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rdata_d = load_extract(funct3_q, addr_q[1:0], mem_read_data);
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = store_merge(funct3_q, addr_q[1:0], mem_read_data, wdata_q);
                state_d = S_STORE;
            end
            S_STORE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            merge_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Outputs decoded from the state register; the write strobe is also killed by reset
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        resp_valid     = (state_q == S_RESP);
        resp_rdata     = rdata_q;
        resp_fault     = fault_q;
        mem_addr       = addr_q;
        mem_read       = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        mem_write      = (state_q == S_STORE) && rst_n && we_q;
        mem_write_data = 32'h0000_0000;
        if (state_q == S_STORE) begin
            mem_write_data = (funct3_q == 3'b010) ? wdata_q : merge_q;
        end else begin
            mem_write_data = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = addr[7:2]; pre_data = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // One request; returns result, fault, latency in cycles, and read/write strobe counts.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt, output int lat, output int nr, output int nw);
        logic done;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        lat = 0; nr = 0; nw = 0; done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_read) nr++;
            if (mem_write) nw++;
            if (resp_valid) done = 1'b1;
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        flt = resp_fault;
    endtask

    logic [31:0] rd;
    logic        flt;
    int          lat, nr, nw;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] exp;
    } req_t;

    req_t seq [4];

    initial begin
        rst_n = 1'b0; pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'd0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0044; req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) preload(i * 4, 32'h0000_0000);

        // reset values while request lines are active
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_untouched", mem[17], 32'd0);
        req_valid = 1'b0; rst_n = 1'b1;

        // SW then LW
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, flt, lat, nr, nw);
        chk("sw_lat", lat, 32'd2);
        chk("sw_nw", nw, 32'd1);
        chk("sw_fault", {31'd0, flt}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        txn(1'b0, 3'b010, 32'h10, 32'd0, rd, flt, lat, nr, nw);
        chk("lw_lat", lat, 32'd2);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_fault", {31'd0, flt}, 32'd0);

        // sub-word loads
        preload(32'h20, 32'h80FF_7F01);
        txn(1'b0, 3'b000, 32'h23, 32'd0, rd, flt, lat, nr, nw); chk("lb_23", rd, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h23, 32'd0, rd, flt, lat, nr, nw); chk("lbu_23", rd, 32'h0000_0080);
        txn(1'b0, 3'b000, 32'h20, 32'd0, rd, flt, lat, nr, nw); chk("lb_20", rd, 32'h0000_0001);
        txn(1'b0, 3'b001, 32'h22, 32'd0, rd, flt, lat, nr, nw); chk("lh_22", rd, 32'hFFFF_80FF);
        txn(1'b0, 3'b101, 32'h22, 32'd0, rd, flt, lat, nr, nw); chk("lhu_22", rd, 32'h0000_80FF);
        txn(1'b0, 3'b100, 32'h21, 32'd0, rd, flt, lat, nr, nw); chk("lbu_21", rd, 32'h0000_007F);

        // read-modify-write stores
        preload(32'h30, 32'h1122_3344);
        txn(1'b1, 3'b000, 32'h31, 32'hFFFF_FFAB, rd, flt, lat, nr, nw);
        chk("sb_lat", lat, 32'd3);
        chk("sb_nw", nw, 32'd1);
        chk("sb_nr", nr, 32'd1);
        txn(1'b0, 3'b010, 32'h30, 32'd0, rd, flt, lat, nr, nw); chk("sb_word", rd, 32'h1122_AB44);
        txn(1'b1, 3'b001, 32'h32, 32'h1234_CDEF, rd, flt, lat, nr, nw);
        chk("sh_lat", lat, 32'd3);
        chk("sh_nw", nw, 32'd1);
        txn(1'b0, 3'b010, 32'h30, 32'd0, rd, flt, lat, nr, nw); chk("sh_word", rd, 32'hCDEF_AB44);

        // faults
        txn(1'b0, 3'b010, 32'h41, 32'd0, rd, flt, lat, nr, nw);
        chk("f_lw_lat", lat, 32'd1); chk("f_lw_flt", {31'd0, flt}, 32'd1);
        chk("f_lw_rd", rd, 32'd0); chk("f_lw_acc", nr + nw, 32'd0);
        txn(1'b1, 3'b001, 32'h43, 32'h0000_FFFF, rd, flt, lat, nr, nw);
        chk("f_sh_lat", lat, 32'd1); chk("f_sh_flt", {31'd0, flt}, 32'd1);
        chk("f_sh_rd", rd, 32'd0); chk("f_sh_acc", nr + nw, 32'd0);
        chk("f_sh_mem", mem[16], 32'd0);
        txn(1'b0, 3'b011, 32'h20, 32'd0, rd, flt, lat, nr, nw);
        chk("f_ld011_lat", lat, 32'd1); chk("f_ld011_flt", {31'd0, flt}, 32'd1);
        chk("f_ld011_rd", rd, 32'd0); chk("f_ld011_acc", nr + nw, 32'd0);
        txn(1'b1, 3'b100, 32'h20, 32'd0, rd, flt, lat, nr, nw);
        chk("f_st100_flt", {31'd0, flt}, 32'd1);
        chk("f_st100_mem", mem[8], 32'h80FF_7F01);

        // reset during STORE of SW
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        chk("rst_store_pre_we", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_store_we", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        chk("rst_store_nvalid1", {31'd0, resp_valid}, 32'd0);
        chk("rst_store_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("rst_store_nvalid2", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1; req_valid = 1'b0;
        chk("rst_store_mem", mem[20], 32'd0);
        txn(1'b0, 3'b010, 32'h50, 32'd0, rd, flt, lat, nr, nw);
        chk("rst_store_lw", rd, 32'd0);

        // back-to-back with req_valid held high, inputs scrambled while busy
        seq[0] = '{1'b1, 3'b010, 32'h60, 32'hA5A5_A5A5, 2, 32'h0};
        seq[1] = '{1'b0, 3'b010, 32'h60, 32'h0,          2, 32'hA5A5_A5A5};
        seq[2] = '{1'b1, 3'b000, 32'h61, 32'h0000_003C, 3, 32'h0};
        seq[3] = '{1'b0, 3'b101, 32'h60, 32'h0,          2, 32'h0000_3CA5};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = seq[i].we; req_funct3 = seq[i].f3;
            req_addr = seq[i].addr; req_wdata = seq[i].wd;
            chk($sformatf("b2b%0d_ready_idle", i), {31'd0, req_ready}, 32'd1);
            chk($sformatf("b2b%0d_nvalid_idle", i), {31'd0, resp_valid}, 32'd0);
            for (int k = 1; k <= seq[i].lat; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    req_we = ~seq[i].we; req_funct3 = 3'b000;
                    req_addr = 32'h0000_0064; req_wdata = 32'h0BAD_0BAD;
                end
                chk($sformatf("b2b%0d_ready_busy%0d", i, k), {31'd0, req_ready}, 32'd0);
                chk($sformatf("b2b%0d_valid%0d", i, k), {31'd0, resp_valid}, {31'd0, k == seq[i].lat});
                if (k == seq[i].lat) chk($sformatf("b2b%0d_rdata", i), resp_rdata, seq[i].exp);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_mem", mem[24], 32'hA5A5_3CA5);
        chk("b2b_mem_ignored", mem[25], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
